// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction ROM port, execute redirect, decode handshake and fault status.
// Latency: pure wiring, no storage.
// Backpressure: out_valid/out_ready handshake toward decode; the ROM and redirect paths have none.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the misalign status bit.
interface fetch_unit_if #(
    parameter int N = 32
);
    // ROM side: word address out, combinational data back
    logic [5:0]   imem_addr;
    logic [N-1:0] imem_q;

    // redirect from execute
    logic         br_taken;
    logic [63:0]  br_target;

    // head of the fetch queue toward decode
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_instr;
    logic [63:0]  out_pc;

    // sticky status
    logic         fault;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         misalign;
`endif

`ifdef FETCH_ALIGN_CHECK_EN
    modport master (
        output imem_addr,
        input  imem_q,
        input  br_taken,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault,
        output misalign
    );

    modport slave (
        input  imem_addr,
        output imem_q,
        output br_taken,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault,
        input  misalign
    );
`else
    modport master (
        output imem_addr,
        input  imem_q,
        input  br_taken,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_q,
        output br_taken,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault
    );
`endif

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: drives ROM word address from PC, queues {pc, instr} pairs, flags out-of-range fetches.
// Latency: fetched word visible at the queue head one cycle after its address is presented; redirect costs one empty cycle.
// Backpressure: fetch stalls while the queue is full unless the head drains in the same cycle; out_ready ignored when empty.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned PC also faults and sets the misalign flag).
module fetch_unit #(
    parameter int N          = 32,
    parameter int DEPTH      = 2,
    parameter int IMEM_WORDS = 19
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;

    // queue storage; contents are don't-care while empty so it carries no reset
    logic [63:0]   pc_mem    [DEPTH];
    logic [N-1:0]  instr_mem [DEPTH];

    logic          in_range;
    logic          pc_ok;
    logic          head_vld;
    logic          deq;
    logic          slot_free;
    logic          fetch_try;
    logic          enq;
    logic          fault_go;

`ifdef FETCH_ALIGN_CHECK_EN
    logic          misalign_q, misalign_d;
`endif

    // Word index compared at full width so huge targets are caught too.
    assign in_range  = (pc_q[63:2] < 62'(IMEM_WORDS));

`ifdef FETCH_ALIGN_CHECK_EN
    assign pc_ok     = in_range && (pc_q[1:0] == 2'b00);
`else
    // Low PC bits ride along into out_pc; fetch only uses the word address.
    assign pc_ok     = in_range;
`endif

    assign head_vld  = (cnt_q != '0);
    assign deq       = head_vld && bus.out_ready;
    // A full queue still accepts when the head leaves this same cycle.
    assign slot_free = (cnt_q < CW'(DEPTH)) || deq;
    // A fetch would happen this cycle if the PC were good; the PC check then picks enqueue or fault.
    assign fetch_try = (state_q == RUN) && !bus.br_taken && slot_free;
    assign enq       = fetch_try && pc_ok;
    assign fault_go  = fetch_try && !pc_ok;

    // Next-state and pointer/count/PC update; redirect wins over everything except reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (bus.br_taken) begin
            // flush: any same-cycle dequeue is dropped along with the rest
            state_d = RUN;
            pc_d    = bus.br_target;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (fault_go) begin
                state_d = FAULT;
            end
            if (enq) begin
                pc_d = pc_q + 64'd4;
                wr_d = wr_q + PW'(1);
            end
            if (deq) begin
                rd_d = rd_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State, PC and queue bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Capture the combinational ROM word together with the PC that addressed it.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            pc_mem[wr_q]    <= pc_q;
            instr_mem[wr_q] <= bus.imem_q;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misalign flag: set when a fault is caused by a misaligned PC, cleared by redirect.
    always_comb begin
        misalign_d = misalign_q;
        if (bus.br_taken) begin
            misalign_d = 1'b0;
        end else if (fault_go && (pc_q[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign = misalign_q;
`endif

    assign bus.imem_addr = pc_q[7:2];
    assign bus.out_valid = head_vld;
    assign bus.out_instr = instr_mem[rd_q];
    assign bus.out_pc    = pc_mem[rd_q];
    // fault is sticky simply because FAULT is only left by redirect or reset
    assign bus.fault     = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized ready/redirect/reset traffic.
// Reference: transaction-level queue model of the fetch rules, updated once per clock edge.
// Outputs sampled 1 time unit after each rising edge.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam int WORDS = 19;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;

    logic [31:0] rom [64];

    fetch_unit_if #(.N(32)) bus ();

    fetch_unit #(
        .N(32),
        .DEPTH(DEPTH),
        .IMEM_WORDS(WORDS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // combinational ROM
    assign bus.imem_q = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    ent_t        mq[$];
    logic [63:0] mpc;
    bit          mflt;
    bit          mmis;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // one clock edge worth of fetch rules, applied to the model
    task automatic model_edge();
        bit   deq;
        bit   room;
        bit   ok;
        ent_t e;
        if (reset) begin
            mq.delete();
            mpc  = 64'd0;
            mflt = 1'b0;
            mmis = 1'b0;
        end else if (bus.br_taken) begin
            mq.delete();
            mpc  = bus.br_target;
            mflt = 1'b0;
            mmis = 1'b0;
        end else begin
            deq  = (mq.size() != 0) && bus.out_ready;
            room = (mq.size() < DEPTH) || deq;
            if (deq) e = mq.pop_front();
            if (!mflt && room) begin
                ok = ((mpc >> 2) < 64'(WORDS));
`ifdef FETCH_ALIGN_CHECK_EN
                if (mpc[1:0] != 2'b00) begin
                    ok   = 1'b0;
                    mmis = 1'b1;
                end
`endif
                if (ok) begin
                    e.pc    = mpc;
                    e.instr = rom[mpc[7:2]];
                    mq.push_back(e);
                    mpc = mpc + 64'd4;
                end else begin
                    mflt = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", bus.out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_instr", bus.out_instr, mq[0].instr);
        end
        chk("imem_addr", bus.imem_addr, mpc[7:2]);
        chk("fault", bus.fault, mflt);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign", bus.misalign, mmis);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] last_word;
        logic [63:0] head_pc;
        logic [63:0] w;
        logic [63:0] lo;

        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0]  = 32'hf8000000;
        rom[1]  = 32'hf8008001;
        rom[15] = 32'hcb0e01ce;
        rom[18] = 32'hf803800f;

        mpc  = 64'd0;
        mflt = 1'b0;
        mmis = 1'b0;

        // reset, ready held high
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        bus.br_taken  = 1'b0;
        bus.br_target = 64'd0;
        step();
        step();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_addr", bus.imem_addr, 6'd0);

        // streaming from word 0
        reset = 1'b0;
        step();
        chk("first_instr", bus.out_instr, 32'hf8000000);
        chk("first_pc", bus.out_pc, 64'd0);
        step();
        chk("second_instr", bus.out_instr, 32'hf8008001);
        chk("second_pc", bus.out_pc, 64'd4);
        for (int i = 0; i < 3; i++) step();

        // stall from reset: queue saturates, pc stops at 8
        reset = 1'b1;
        step();
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall_addr", bus.imem_addr, 6'd2);
        chk("stall_head", bus.out_pc, 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("drain_pc4", bus.out_pc, 64'd4);
        step();
        chk("drain_pc8", bus.out_pc, 64'd8);

        // redirect with a full queue
        bus.out_ready = 1'b0;
        step();
        step();
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h3C;
        step();
        chk("redir_gap", bus.out_valid, 1'b0);
        chk("redir_addr", bus.imem_addr, 6'd15);
        bus.br_taken  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("redir_pc", bus.out_pc, 64'h3C);
        chk("redir_instr", bus.out_instr, 32'hcb0e01ce);

        // run off the populated ROM
        last_word = 32'd0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid && bus.out_pc == 64'h48) last_word = bus.out_instr;
        end
        chk("last_word", last_word, 32'hf803800f);
        chk("fault_set", bus.fault, 1'b1);
        chk("fault_addr", bus.imem_addr, 6'd19);
        chk("fault_drained", bus.out_valid, 1'b0);

        // redirect clears fault and fetch resumes
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h0;
        step();
        chk("fault_clear", bus.fault, 1'b0);
        bus.br_taken = 1'b0;
        step();
        chk("resume_pc", bus.out_pc, 64'd0);
        chk("resume_instr", bus.out_instr, 32'hf8000000);

        // full queue with simultaneous enqueue and dequeue keeps order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        head_pc       = bus.out_pc;
        bus.out_ready = 1'b1;
        step();
        chk("full_order1", bus.out_pc, head_pc + 64'd4);
        step();
        chk("full_order2", bus.out_pc, head_pc + 64'd8);

        // reset together with redirect
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h20;
        reset         = 1'b1;
        step();
        chk("rstbr_valid", bus.out_valid, 1'b0);
        chk("rstbr_fault", bus.fault, 1'b0);
        chk("rstbr_addr", bus.imem_addr, 6'd0);
        reset        = 1'b0;
        bus.br_taken = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.br_taken  = ($urandom_range(0, 15) == 0);
            w  = 64'($urandom_range(0, 23));
            lo = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 3)) : 64'd0;
            bus.br_target = ($urandom_range(0, 31) == 0) ? 64'h1_0000_0040 : ((w << 2) | lo);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset        = 1'b0;
        bus.br_taken = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
